ad5791_cfg_sequencer: RTL

- Sequences configuration writes (control, clearcode, software-control registers) to the six-channel AD5791 serial DAC driver.
- Drives the driver's configuration interface: config mode, axis select, config word stream and send strobe. Walks the axes in a mask one at a time and waits on the driver's ready flag between writes.
- Sits between the PS-side register bank and the DAC driver. Normal streaming resumes only after the sequence releases config mode.

---
 rtl/ad5791_cfg_sequencer_if.sv | 29 ++
 rtl/ad5791_cfg_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5791_cfg_sequencer_if.sv
// rtl/ad5791_cfg_sequencer_if.sv - configuration-side link between the sequencer and the AD5791 driver
interface ad5791_cfg_sequencer_if #(
    parameter int SAXIS_TDATA_WIDTH = 32
);
    logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata;
    logic                         M_AXISCFG_tvalid;
    logic                         configuration_mode;
    logic [2:0]                   configuration_axis;
    logic                         configuration_send;
    logic                         dac_ready;

    modport master (
        output M_AXISCFG_tdata,
        output M_AXISCFG_tvalid,
        output configuration_mode,
        output configuration_axis,
        output configuration_send,
        input  dac_ready
    );

    modport slave (
        input  M_AXISCFG_tdata,
        input  M_AXISCFG_tvalid,
        input  configuration_mode,
        input  configuration_axis,
        input  configuration_send,
        output dac_ready
    );
endinterface

// File: rtl/ad5791_cfg_sequencer.sv
// rtl/ad5791_cfg_sequencer.sv - walks an axis mask writing one config word per AD5791 axis
// Optional self-start after reset with INIT_WORD on all axes: AD5791_CFG_AUTO_INIT_EN
module ad5791_cfg_sequencer #(
    parameter int NUM_DAC           = 6,
    parameter int DAC_WORD_WIDTH    = 24,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MODE_SETTLE       = 8,
    parameter int START_TIMEOUT     = 256,
    parameter int DONE_TIMEOUT      = 1024,
    parameter int SEND_GAP          = 16
`ifdef AD5791_CFG_AUTO_INIT_EN
    ,
    parameter logic [DAC_WORD_WIDTH-1:0] INIT_WORD = 24'h200012
`endif
) (
    input  logic                      a_clk,
    input  logic                      a_rst,
    input  logic                      start,
    input  logic [NUM_DAC-1:0]        axis_mask,
    input  logic [DAC_WORD_WIDTH-1:0] cfg_word,
    ad5791_cfg_sequencer_if.master    cfg,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [2:0]                err_axis,
    output logic [NUM_DAC-1:0]        skipped_mask
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENTER,
        S_SELECT,
        S_LOAD,
        S_WAIT_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_RELEASE,
        S_EXIT,
        S_DONE
    } state_t;

    localparam logic [10:0] SETTLE_LAST = 11'(MODE_SETTLE - 1);
    localparam logic [10:0] START_LAST  = 11'(START_TIMEOUT - 1);
    localparam logic [10:0] DONE_LAST   = 11'(DONE_TIMEOUT - 1);
    localparam logic [10:0] GAP_LAST    = 11'(SEND_GAP - 1);

    state_t                    state_q;
    state_t                    state_d;
    logic [10:0]               cnt_q;
    logic                      rdy_m;
    logic                      rdy_s;
    logic [DAC_WORD_WIDTH-1:0] word_q;
    logic [NUM_DAC-1:0]        rem_q;
    logic [2:0]                axis_q;
    logic [2:0]                sel_idx;
    logic                      zero_done_q;

    logic                      req;
    logic [DAC_WORD_WIDTH-1:0] go_word;
    logic [NUM_DAC-1:0]        go_mask;
    logic                      seq_go;
    logic                      zero_req;
    logic                      do_select;
    logic                      do_skip;
    logic                      do_err;

    // dac_ready comes from the driver's SPI domain
    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= cfg.dac_ready;
            rdy_s <= rdy_m;
        end
    end

`ifdef AD5791_CFG_AUTO_INIT_EN
    logic auto_pend_q;

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            auto_pend_q <= 1'b1;
        end else if (state_q == S_IDLE) begin
            auto_pend_q <= 1'b0;
        end
    end

    always_comb begin
        req     = start | auto_pend_q;
        go_word = auto_pend_q ? INIT_WORD : cfg_word;
        go_mask = auto_pend_q ? {NUM_DAC{1'b1}} : axis_mask;
    end
`else
    always_comb begin
        req     = start;
        go_word = cfg_word;
        go_mask = axis_mask;
    end
`endif

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_DAC - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // every state entry restarts its own bound; the count parks at all-ones
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != 11'h7FF) begin
                cnt_q <= cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_go    = 1'b0;
        zero_req  = 1'b0;
        do_select = 1'b0;
        do_skip   = 1'b0;
        do_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    seq_go = 1'b1;
                    if (go_mask == '0) begin
                        zero_req = 1'b1;
                    end else begin
                        state_d = S_ENTER;
                    end
                end
            end
            S_ENTER: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                do_select = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rdy_s) begin
                    state_d = S_SEND;
                end else if (cnt_q >= DONE_LAST) begin
                    do_err  = 1'b1;
                    state_d = S_EXIT;
                end
            end
            S_SEND: begin
                // ready never falling means the driver saw unchanged data and ignored us
                if (!rdy_s) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= START_LAST) begin
                    do_skip = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_WAIT_DONE: begin
                if (rdy_s) begin
                    state_d = S_RELEASE;
                end else if (cnt_q >= DONE_LAST) begin
                    do_err  = 1'b1;
                    state_d = S_EXIT;
                end
            end
            S_RELEASE: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = (rem_q != '0) ? S_SELECT : S_EXIT;
                end
            end
            S_EXIT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            word_q       <= '0;
            rem_q        <= '0;
            axis_q       <= '0;
            zero_done_q  <= 1'b0;
            error        <= 1'b0;
            err_axis     <= '0;
            skipped_mask <= '0;
        end else begin
            zero_done_q <= zero_req;
            if (seq_go) begin
                word_q       <= go_word;
                rem_q        <= go_mask;
                error        <= 1'b0;
                err_axis     <= '0;
                skipped_mask <= '0;
            end
            // axis moves only in SELECT/EXIT, where send and tvalid are both low
            if (do_select) begin
                axis_q         <= sel_idx;
                rem_q[sel_idx] <= 1'b0;
            end
            if (state_q == S_EXIT) begin
                axis_q <= '0;
            end
            if (do_skip) begin
                skipped_mask[axis_q] <= 1'b1;
            end
            if (do_err) begin
                error    <= 1'b1;
                err_axis <= axis_q;
            end
        end
    end

    always_comb begin
        cfg.M_AXISCFG_tvalid   = (state_q == S_LOAD);
        cfg.M_AXISCFG_tdata    = cfg.M_AXISCFG_tvalid
                                 ? {{(SAXIS_TDATA_WIDTH - DAC_WORD_WIDTH){1'b0}}, word_q}
                                 : '0;
        cfg.configuration_mode = state_q inside {S_ENTER, S_SELECT, S_LOAD, S_WAIT_IDLE,
                                                 S_SEND, S_WAIT_DONE, S_RELEASE};
        cfg.configuration_axis = axis_q;
        cfg.configuration_send = (state_q == S_SEND) || (state_q == S_WAIT_DONE);
        busy                   = (state_q != S_IDLE) && (state_q != S_DONE);
        done                   = (state_q == S_DONE) || zero_done_q;
    end

endmodule
